// File: rtl/l2_cache_miss_fill_queue_pkg.sv
// rtl/l2_cache_miss_fill_queue_pkg.sv - shared line/tag types for the L2 miss fill queue
package l2_cache_miss_fill_queue_pkg;

  localparam int CACHE_LINE_BITS  = 512;
  localparam int LINE_OFFSET_BITS = 6;
  localparam int LINE_INDEX_BITS  = 32 - LINE_OFFSET_BITS;
  localparam int L2_FILL_ID_WIDTH = 4;

  typedef logic [LINE_INDEX_BITS-1:0]  cache_line_index_t;
  typedef logic [CACHE_LINE_BITS-1:0]  cache_line_data_t;
  typedef logic [L2_FILL_ID_WIDTH-1:0] l2_fill_id_t;

  function automatic logic [31:0] line_byte_addr(input cache_line_index_t idx);
    return {idx, {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_cache_miss_fill_queue_if.sv
// rtl/l2_cache_miss_fill_queue_if.sv - enqueue, memory and fill handshakes of the miss fill queue
interface l2_cache_miss_fill_queue_if
  import l2_cache_miss_fill_queue_pkg::*;
#(
  parameter int ID_WIDTH       = L2_FILL_ID_WIDTH,
  parameter int MEM_DATA_WIDTH = 32
) ();

  logic                      enqueue_valid;
  cache_line_index_t         enqueue_addr;
  logic [ID_WIDTH-1:0]       enqueue_id;
  logic                      queue_almost_full;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [31:0]               mem_req_addr;
  logic                      mem_rdata_valid;
  logic [MEM_DATA_WIDTH-1:0] mem_rdata;
  logic                      mem_rdata_ready;

  logic                      fill_valid;
  logic                      fill_ready;
  cache_line_index_t         fill_addr;
  logic [ID_WIDTH-1:0]       fill_id;
  cache_line_data_t          fill_data;

  modport slave (
    input  enqueue_valid, enqueue_addr, enqueue_id,
    output queue_almost_full,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rdata_valid, mem_rdata,
    output mem_rdata_ready,
    output fill_valid, fill_addr, fill_id, fill_data,
    input  fill_ready
  );

  modport master (
    output enqueue_valid, enqueue_addr, enqueue_id,
    input  queue_almost_full,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rdata_valid, mem_rdata,
    input  mem_rdata_ready,
    input  fill_valid, fill_addr, fill_id, fill_data,
    output fill_ready
  );

endinterface

// File: rtl/l2_cache_miss_fill_queue_sync_fifo.sv
// rtl/l2_cache_miss_fill_queue_sync_fifo.sv - synchronous FIFO with occupancy and registered almost-full
module sync_fifo #(
  parameter int WIDTH                 = 8,
  parameter int SIZE                  = 16,
  parameter int ALMOST_FULL_THRESHOLD = SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic                        empty,
  output logic                        full,
  output logic                        almost_full,
  output logic [$clog2(SIZE+1)-1:0]   count
);

  localparam int PTR_W   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int COUNT_W = $clog2(SIZE + 1);

  logic [WIDTH-1:0]   mem [SIZE];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push_ok;
  logic               pop_ok;
  logic [COUNT_W-1:0] count_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == COUNT_W'(SIZE));
  assign pop_ok    = pop && !empty;
  // a push into a full FIFO is only legal when the head leaves in the same cycle
  assign push_ok   = push && (!full || pop_ok);
  assign head_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push_ok && !pop_ok) begin
      count_next = count + COUNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count       <= count_next;
      almost_full <= (count_next >= COUNT_W'(ALMOST_FULL_THRESHOLD));
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/l2_cache_miss_fill_queue.sv
// rtl/l2_cache_miss_fill_queue.sv - issues queued L2 line misses to memory one at a time and returns assembled lines as fills
module l2_cache_miss_fill_queue
  import l2_cache_miss_fill_queue_pkg::*;
#(
  parameter int QUEUE_SIZE         = 16,
  parameter int ALMOST_FULL_MARGIN = 4,
  parameter int MEM_DATA_WIDTH     = 32,
  parameter int ID_WIDTH           = L2_FILL_ID_WIDTH,
  parameter bit PROTOCOL_ASSERTS   = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  l2_cache_miss_fill_queue_if.slave  bus
);

  localparam int BEATS   = CACHE_LINE_BITS / MEM_DATA_WIDTH;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ENTRY_W = $bits(cache_line_index_t) + ID_WIDTH;
  localparam int COUNT_W = $clog2(QUEUE_SIZE + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] FILL = 2'd3;

  logic [1:0]          state;
  logic [BEAT_W-1:0]   beat_cnt;
  cache_line_data_t    line_buf;
  logic [ENTRY_W-1:0]  head_entry;
  cache_line_index_t   head_addr;
  logic [ID_WIDTH-1:0] head_id;
  logic                fifo_empty;
  logic                fifo_full;
  logic                fifo_almost_full;
  logic [COUNT_W-1:0]  occupancy;
  logic                fill_fire;
  logic                enq_accept;
  logic                enq_dropped;
  logic                stray_beat;
  logic                more_after_pop;

  // the head stays queued until its fill is granted, so occupancy includes the in-flight miss
  assign fill_fire      = (state == FILL) && bus.fill_ready;
  assign enq_accept     = bus.enqueue_valid && (!fifo_full || fill_fire);
  assign enq_dropped    = bus.enqueue_valid && !enq_accept;
  assign stray_beat     = bus.mem_rdata_valid && (state != DATA);
  assign more_after_pop = (occupancy > COUNT_W'(1)) || enq_accept;
  assign {head_addr, head_id} = head_entry;

  sync_fifo #(
    .WIDTH                 (ENTRY_W),
    .SIZE                  (QUEUE_SIZE),
    .ALMOST_FULL_THRESHOLD (QUEUE_SIZE - ALMOST_FULL_MARGIN)
  ) u_req_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (enq_accept),
    .push_data   ({bus.enqueue_addr, bus.enqueue_id}),
    .pop         (fill_fire),
    .head_data   (head_entry),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .almost_full (fifo_almost_full),
    .count       (occupancy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) state <= ADDR;
        ADDR: if (bus.mem_req_ready) state <= DATA;
        DATA: begin
          if (bus.mem_rdata_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              state    <= FILL;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        default: begin
          if (bus.fill_ready) state <= more_after_pop ? ADDR : IDLE;
        end
      endcase
    end
  end

  // beats shift in at the bottom, so after the last one beat 0 sits in the top word
  always_ff @(posedge clk) begin
    if (!reset && (state == DATA) && bus.mem_rdata_valid) begin
      line_buf <= CACHE_LINE_BITS'({line_buf, bus.mem_rdata});
    end
  end

  always_ff @(posedge clk) begin
    if (PROTOCOL_ASSERTS && !reset) begin
      assert (!enq_dropped);
      assert (!stray_beat);
    end
  end

  assign bus.queue_almost_full = fifo_almost_full;
  assign bus.mem_req_valid     = (state == ADDR);
  assign bus.mem_req_addr      = (state == ADDR) ? line_byte_addr(head_addr) : '0;
  assign bus.mem_rdata_ready   = (state == DATA);
  assign bus.fill_valid        = (state == FILL);
  assign bus.fill_addr         = (state == FILL) ? head_addr : '0;
  assign bus.fill_id           = (state == FILL) ? head_id : '0;
  assign bus.fill_data         = (state == FILL) ? line_buf : '0;

endmodule

// File: doc/l2_cache_miss_fill_queue.md
Name: l2_cache_miss_fill_queue

Overview:
Memory-facing end of the L2 miss path.
- Accepts line-load requests that the L2 pipeline enqueues on a miss.
- Issues them one at a time to system memory and assembles the returned beats into a full cache line.
- Re-injects each completed line into the L2 pipeline as a fill (restart) transaction. That restart is the event that clears the line's pending-miss entry upstream.

Parameters:
QUEUE_SIZE, 16, pending request entries; must be >= pending-miss tracker depth
ALMOST_FULL_MARGIN, 4, free entries reserved for requests already in the L2 pipeline
MEM_DATA_WIDTH, 32, memory read data bus width; must divide CACHE_LINE_BITS
ID_WIDTH, 4, opaque requester tag carried from enqueue to fill

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enqueue_valid  in  1  load request from L2 pipeline
enqueue_addr  in  cache_line_index_t  line to fetch
enqueue_id  in  ID_WIDTH  requester tag
queue_almost_full  out  1  high when free entries <= ALMOST_FULL_MARGIN
mem_req_valid  out  1  memory read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  byte address = {line index, 6'b0}
mem_rdata_valid  in  1  read beat valid
mem_rdata  in  MEM_DATA_WIDTH  read beat
mem_rdata_ready  out  1  block accepts read beat
fill_valid  out  1  fill transaction to L2 arbiter
fill_ready  in  1  arbiter grants fill
fill_addr  out  cache_line_index_t  filled line
fill_id  out  ID_WIDTH  tag of filled request
fill_data  out  cache_line_data_t  assembled line

Behaviour:
- Clock/reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state IDLE, occupancy 0, beat counter 0. mem_req_valid, mem_rdata_ready and fill_valid all 0. queue_almost_full 0.
- Queue: FIFO of {addr, id}. An entry stays in the FIFO until its fill handshake completes, so occupancy counts the in-flight request.
- Enqueue: accepted when occupancy < QUEUE_SIZE, or when occupancy == QUEUE_SIZE and a fill handshake completes in the same cycle.
  - Enqueue while full with no dequeue: assertion failure; the request is dropped.
- Only one memory transaction is outstanding at a time.
- FSM:
  - IDLE -> ADDR when the FIFO is non-empty; the head entry is used. Transition takes one cycle; an entry enqueued into an empty FIFO sees mem_req_valid at the earliest 2 cycles later.
  - ADDR: mem_req_valid=1 with head address. mem_req_addr stays stable while valid is asserted. Goes to DATA on mem_req_valid & mem_req_ready.
  - DATA: mem_rdata_ready=1. Each mem_rdata_valid beat is written to the line buffer and the beat counter increments.
    - Beat k occupies fill_data bits [CACHE_LINE_BITS-1-k*MEM_DATA_WIDTH -: MEM_DATA_WIDTH], so beat 0 is the most significant word.
    - After the last beat (CACHE_LINE_BITS/MEM_DATA_WIDTH - 1) the counter wraps to 0 and the FSM goes to FILL.
  - FILL: fill_valid=1. fill_addr, fill_id and fill_data come from the head entry and line buffer, and are held stable until fill_ready.
    - On fill_valid & fill_ready: FIFO pops. Next state is ADDR if the FIFO is non-empty after the pop and any same-cycle enqueue, otherwise IDLE. The ADDR transition is back-to-back with no IDLE bubble.
- mem_rdata_valid outside DATA is ignored (ready=0). A beat arriving while no beat is expected is a protocol assertion.
- queue_almost_full is registered from the next-cycle occupancy: (QUEUE_SIZE - occupancy) <= ALMOST_FULL_MARGIN.
- Reset mid-operation: the FSM aborts to IDLE; queue contents and the partial line are discarded. Late memory beats are not accepted. The upstream tracker is reset by the same reset.

Decomposition:
- Package defines: existing cache_line_index_t, cache_line_data_t, CACHE_LINE_BITS. Add l2_fill_id_t (ID_WIDTH).
- Request FIFO is the existing sync_fifo sub-module, instantiated as sync_fifo #(WIDTH=$bits(cache_line_index_t)+ID_WIDTH, SIZE=QUEUE_SIZE). Its almost_full threshold is set to QUEUE_SIZE-ALMOST_FULL_MARGIN.
- FSM, beat counter and line buffer are local to this module.

Test Plan:
- Single miss, addr 0x1234, id 3, memory returns beats 0..15 = 0x0..0xF -> mem_req_addr 0x48D00. After 16 beats, fill_valid with fill_addr 0x1234, fill_id 3, fill_data[511:480]=0x0, [31:0]=0xF.
- Three enqueues back-to-back (0x10, 0x20, 0x30), fill_ready tied 1 -> three fills in order. Each next mem_req_valid occurs the cycle after the prior fill handshake.
- mem_req_ready held 0 for 5 cycles, then fill_ready held 0 for 7 cycles -> mem_req_addr and fill outputs stay stable; no pop until fill_ready=1.
- Fill 16 entries -> occupancy 16; queue_almost_full rises when occupancy reaches 12. Enqueue with simultaneous fill handshake at 16 is accepted, and occupancy stays 16.
- Assert reset after beat 7 of 16 -> next cycle all outputs 0 and state IDLE. Remaining beats are not accepted. A new enqueue of 0x55 is fetched with a fresh beat count.
- mem_rdata_valid pulsed during IDLE and ADDR -> mem_rdata_ready=0, line buffer unchanged, protocol assertion fires.
